// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the switch debouncer.
// Counter width is derived here so every bit uses the same sizing rule.
package switch_debouncer_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

    // Wide enough to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced input: 2-flop synchronizer, steady-time counter,
// accepted level flop and registered rise/fall pulses.
module debounce_bit
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;
    logic             differ;
    logic             accept;

    // Accept on the D-th consecutive differing sample; the counter stops at
    // CNT_LAST and returns to zero on acceptance or on any matching sample.
    always_comb begin
        differ   = sync2_q ^ stable_q;
        accept   = differ && (cnt_q == CNT_LAST);
        cnt_d    = '0;
        if (differ && !accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        stable_d = accept ? sync2_q : stable_q;
        rise_d   = accept && sync2_q;
        fall_d   = accept && !sync2_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// N_IN-wide switch/key debouncer with per-bit edge pulses, sticky event
// flags cleared by evt_clear, and a registered any-event summary.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int N_IN            = 32,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] raw_in,
    input  logic            evt_clear,
    output logic [N_IN-1:0] stable_out,
    output logic [N_IN-1:0] rise_pulse,
    output logic [N_IN-1:0] fall_pulse,
    output logic [N_IN-1:0] evt_pending,
    output logic            any_evt
);

    logic [N_IN-1:0] evt_pending_q;
    logic [N_IN-1:0] evt_pending_d;
    logic            any_evt_q;
    logic            any_evt_d;

    for (genvar i = 0; i < N_IN; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk_i   (clk),
            .rst_i   (reset),
            .raw_i   (raw_in[i]),
            .stable_o(stable_out[i]),
            .rise_o  (rise_pulse[i]),
            .fall_o  (fall_pulse[i])
        );
    end

    // A new edge on a bit wins over a coincident clear of that bit.
    always_comb begin
        evt_pending_d = (evt_pending_q & ~{N_IN{evt_clear}}) | rise_pulse | fall_pulse;
        any_evt_d     = |evt_pending_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_pending_q <= '0;
            any_evt_q     <= 1'b0;
        end else begin
            evt_pending_q <= evt_pending_d;
            any_evt_q     <= any_evt_d;
        end
    end

    assign evt_pending = evt_pending_q;
    assign any_evt     = any_evt_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomized and directed bench for switch_debouncer against a
// window-based reference model of the debounce rules.
module tb_switch_debouncer;
    import switch_debouncer_pkg::*;

    localparam int N = 32;
    localparam int D = SIM_DEBOUNCE_CYCLES;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         evt_clear = 1'b0;
    logic [N-1:0] raw_in = '0;
    logic [N-1:0] stable_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic [N-1:0] evt_pending;
    logic         any_evt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: hist[j] is the raw level sampled j edges ago.
    logic [N-1:0] hist [D+2];
    logic [N-1:0] m_stable, m_rise, m_fall, m_pend;
    logic         m_any;

    switch_debouncer #(
        .N_IN(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .evt_clear  (evt_clear),
        .stable_out (stable_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .evt_pending(evt_pending),
        .any_evt    (any_evt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_clear();
        for (int j = 0; j < D + 2; j++) hist[j] = '0;
        m_stable = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_any = 1'b0;
    endtask

    // A bit is accepted when the last D synchronized samples (raw delayed by
    // two edges) all differ from the currently accepted level.
    task automatic model_step();
        logic [N-1:0] acc, np;
        logic         na;
        if (reset) begin
            model_clear();
        end else begin
            for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = raw_in;
            acc = '1;
            for (int j = 2; j <= D + 1; j++) acc &= hist[j] ^ m_stable;
            np = (m_pend & ~{N{evt_clear}}) | m_rise | m_fall;
            na = |m_pend;
            m_rise   = acc & ~m_stable;
            m_fall   = acc & m_stable;
            m_stable = m_stable ^ acc;
            m_pend   = np;
            m_any    = na;
        end
    endtask

    task automatic tick(input logic [N-1:0] r, input logic clr, input logic rst);
        @(negedge clk);
        raw_in = r; evt_clear = clr; reset = rst;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        tick('0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({stable_out, rise_pulse, fall_pulse, evt_pending, any_evt} !== '0) begin
            n_err++;
            $display("FAIL reset_state: stable %h rise %h fall %h pend %h any %b, required all 0",
                     stable_out, rise_pulse, fall_pulse, evt_pending, any_evt);
        end
        tick('1, 1'b0, 1'b0);
        n_vec++;
        if ((rise_pulse | fall_pulse) !== '0) begin
            n_err++;
            $display("FAIL first_cycle_pulse: rise %h fall %h, required 0", rise_pulse, fall_pulse);
        end
    endtask

    task automatic test_rise();
        int lat = 0, nrise = 0;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            tick(32'h1, 1'b0, 1'b0);
            n_vec++;
            if (stable_out !== m_stable || rise_pulse !== m_rise || fall_pulse !== m_fall ||
                evt_pending !== m_pend || any_evt !== m_any) begin
                n_err++;
                $display("FAIL rise_model cyc %0d: stable %h/%h rise %h/%h pend %h/%h (got/exp)",
                         i, stable_out, m_stable, rise_pulse, m_rise, evt_pending, m_pend);
            end
            if (stable_out[0] === 1'b1 && lat == 0) lat = i;
            if (rise_pulse === 32'h1) nrise++;
        end
        n_vec++;
        if (lat != 2 + D || nrise != 1 || evt_pending !== 32'h1) begin
            n_err++;
            $display("FAIL rise_latency: latency %0d pulses %0d pend %h, required %0d 1 00000001",
                     lat, nrise, evt_pending, 2 + D);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            tick((i <= 3) ? 32'h20 : 32'h0, 1'b0, 1'b0);
            n_vec++;
            if (stable_out !== m_stable || rise_pulse !== m_rise || evt_pending !== m_pend ||
                (stable_out | rise_pulse | evt_pending) !== '0) begin
                n_err++;
                $display("FAIL glitch cyc %0d: stable %h rise %h pend %h, required 0",
                         i, stable_out, rise_pulse, evt_pending);
            end
        end
    endtask

    task automatic test_fall();
        int lat = 0, nfall = 0;
        do_reset();
        repeat (8) tick(32'h1, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            tick(32'h0, 1'b0, 1'b0);
            n_vec++;
            if (stable_out !== m_stable || fall_pulse !== m_fall || rise_pulse !== m_rise ||
                evt_pending !== m_pend || any_evt !== m_any || evt_pending[0] !== 1'b1) begin
                n_err++;
                $display("FAIL fall_model cyc %0d: stable %h/%h fall %h/%h pend %h/%h (got/exp)",
                         i, stable_out, m_stable, fall_pulse, m_fall, evt_pending, m_pend);
            end
            if (fall_pulse === 32'h1) begin
                nfall++;
                if (lat == 0) lat = i;
            end
        end
        n_vec++;
        if (lat != 2 + D || nfall != 1) begin
            n_err++;
            $display("FAIL fall_latency: latency %0d pulses %0d, required %0d 1", lat, nfall, 2 + D);
        end
    endtask

    task automatic test_clear_collision();
        bit found = 0;
        do_reset();
        repeat (8) tick(32'h1, 1'b0, 1'b0);
        repeat (8) tick(32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 12 && !found; i++) begin
            tick(32'h1, 1'b0, 1'b0);
            if (m_rise[0]) found = 1;
        end
        n_vec++;
        if (!found || rise_pulse !== 32'h1 || evt_pending !== 32'h1) begin
            n_err++;
            $display("FAIL collision_setup: rise %h pend %h, required 00000001 00000001",
                     rise_pulse, evt_pending);
        end
        tick(32'h1, 1'b1, 1'b0);
        n_vec++;
        if (evt_pending !== 32'h1 || any_evt !== 1'b1 || evt_pending !== m_pend) begin
            n_err++;
            $display("FAIL clear_vs_set: pend %h any %b, required 00000001 1", evt_pending, any_evt);
        end
        tick(32'h1, 1'b1, 1'b0);
        n_vec++;
        if (evt_pending !== 32'h0 || any_evt !== 1'b1) begin
            n_err++;
            $display("FAIL clear_alone: pend %h any %b, required 00000000 1", evt_pending, any_evt);
        end
        tick(32'h1, 1'b0, 1'b0);
        n_vec++;
        if (evt_pending !== 32'h0 || any_evt !== 1'b0 || any_evt !== m_any) begin
            n_err++;
            $display("FAIL any_evt_lag: pend %h any %b, required 00000000 0", evt_pending, any_evt);
        end
    endtask

    task automatic test_reset_mid();
        int lat = 0;
        do_reset();
        repeat (8) tick('1, 1'b0, 1'b0);
        repeat (8) tick('0, 1'b0, 1'b0);
        repeat (4) tick('1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({stable_out, rise_pulse, fall_pulse, evt_pending, any_evt} !== '0) begin
            n_err++;
            $display("FAIL async_reset: stable %h pend %h any %b, required 0 0 0",
                     stable_out, evt_pending, any_evt);
        end
        @(posedge clk);
        model_step();
        for (int i = 1; i <= 12; i++) begin
            tick('1, 1'b0, 1'b0);
            n_vec++;
            if (stable_out !== m_stable || rise_pulse !== m_rise || fall_pulse !== m_fall ||
                evt_pending !== m_pend || any_evt !== m_any) begin
                n_err++;
                $display("FAIL reset_mid_model cyc %0d: stable %h/%h rise %h/%h (got/exp)",
                         i, stable_out, m_stable, rise_pulse, m_rise);
            end
            if (stable_out === '1 && lat == 0) lat = i;
        end
        n_vec++;
        if (lat != 2 + D) begin
            n_err++;
            $display("FAIL reset_mid_latency: latency %0d, required %0d", lat, 2 + D);
        end
    endtask

    task automatic test_independent();
        logic [N-1:0] r, exp_rise;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            r = (i >= 3) ? 32'h8000_0001 : 32'h1;
            tick(r, 1'b0, 1'b0);
            exp_rise = (i == 6) ? 32'h1 : (i == 8) ? 32'h8000_0000 : 32'h0;
            n_vec++;
            if (rise_pulse !== exp_rise || rise_pulse !== m_rise || stable_out !== m_stable) begin
                n_err++;
                $display("FAIL independent cyc %0d: rise %h, required %h (stable %h/%h)",
                         i, rise_pulse, exp_rise, stable_out, m_stable);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r = '0;
        logic         clr, rst;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            r   = r ^ ($urandom & $urandom & $urandom);
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick(r, clr, rst);
            n_vec++;
            if (stable_out !== m_stable || rise_pulse !== m_rise || fall_pulse !== m_fall ||
                evt_pending !== m_pend || any_evt !== m_any) begin
                n_err++;
                $display("FAIL random cyc %0d: stable %h/%h rise %h/%h fall %h/%h pend %h/%h any %b/%b",
                         i, stable_out, m_stable, rise_pulse, m_rise, fall_pulse, m_fall,
                         evt_pending, m_pend, any_evt, m_any);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_fall();
        test_clear_collision();
        test_reset_mid();
        test_independent();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter N_IN, default 32: number of raw input bits; outputs feed the 32-bit switches/input PIO ports.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: cycles an input must be steady before acceptance (10 ms at 50 MHz); legal range 2..2^24.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 raw_in  input  N_IN  asynchronous switch/key levels from board pins.
REQ-006 evt_clear  input  1  synchronous one-cycle pulse that clears evt_pending.
REQ-007 stable_out  output  N_IN  debounced levels, to switchesport/inport export.
REQ-008 rise_pulse  output  N_IN  one-cycle pulse per bit on accepted 0->1.
REQ-009 fall_pulse  output  N_IN  one-cycle pulse per bit on accepted 1->0.
REQ-010 evt_pending  output  N_IN  sticky per-bit change flags.
REQ-011 any_evt  output  1  OR-reduction of evt_pending, registered.

Function
REQ-012 Each raw_in bit shall pass through a 2-flop synchronizer before any other logic.
REQ-013 Per bit, the counter shall reset to 0 whenever the synchronized level equals stable_out.
REQ-014 Per bit, the counter shall increment each cycle while the synchronized level differs from stable_out.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and the level still differs, stable_out shall take the synchronized level next edge and the counter shall return to 0.
REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) shall never change stable_out.
REQ-017 Latency raw edge -> stable_out change shall be exactly 2 + DEBOUNCE_CYCLES cycles for a clean step.
REQ-018 rise_pulse/fall_pulse shall assert in the same cycle stable_out changes, for exactly one cycle.
REQ-019 evt_pending[i] shall set on rise_pulse[i] or fall_pulse[i] and hold until evt_clear.
REQ-020 evt_clear and a simultaneous new event on the same bit: set shall win (flag remains 1).
REQ-021 any_evt shall equal the OR of the previous cycle's evt_pending (one-cycle lag).
REQ-022 Counter width shall be clog2(DEBOUNCE_CYCLES); counter shall never wrap or saturate past DEBOUNCE_CYCLES-1.
REQ-023 Bits shall be fully independent; simultaneous changes on several bits shall each be accepted on their own timeline.

Reset
REQ-024 reset shall asynchronously clear synchronizer flops, counters, stable_out, rise_pulse, fall_pulse, evt_pending and any_evt to 0.
REQ-025 Reset asserted mid-count shall discard the partial count; after release an input held at 1 shall need the full 2 + DEBOUNCE_CYCLES cycles to appear.
REQ-026 No pulse outputs shall assert in the first cycle after reset release.

Structure
REQ-027 Shared package switch_debouncer_pkg shall hold DEBOUNCE_CYCLES default, SIM_DEBOUNCE_CYCLES = 4, and the counter-width function.
REQ-028 Per-bit logic (synchronizer, counter, stable flop, edge pulses) shall be sub-module debounce_bit, instantiated N_IN times by generate.
REQ-029 evt_pending, evt_clear handling and any_evt shall reside in the top module.

Verification (DEBOUNCE_CYCLES = 4, N_IN = 32)
REQ-030 raw_in 0x0 -> 0x00000001 held -> stable_out[0]=1 exactly 6 cycles later; rise_pulse=0x00000001 one cycle; evt_pending=0x00000001.
REQ-031 raw_in[5] high for 3 cycles then low -> stable_out, rise_pulse, evt_pending stay 0x0.
REQ-032 stable_out=0x00000001, raw_in -> 0x0 -> fall_pulse=0x00000001 one cycle after 6 cycles; evt_pending[0] stays 1.
REQ-033 evt_pending=0x00000001, evt_clear pulsed in the same cycle as rise_pulse[0] -> evt_pending stays 0x00000001; evt_clear alone next -> 0x0, any_evt 0 one cycle later.
REQ-034 raw_in=0xFFFFFFFF, reset asserted at count 2 for 1 cycle -> all outputs 0 immediately; stable_out=0xFFFFFFFF 6 cycles after release.
REQ-035 raw_in bits 0 and 31 toggle 2 cycles apart -> rise_pulse 0x00000001 then 0x80000000 2 cycles later, independent.
